counter_sweep_ctrl: RTL and testbench

//  Control stage directly upstream of the N-bit up/down/load counter. Drives the

---
 rtl/counter_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Purpose: drives an up/down/load counter through N lo->hi->lo sweeps and then parks it at lo.
// Latency: LOAD takes 1 cycle and DONE takes 1 cycle; each sweep takes 2*(hi-lo) cycles.
// Backpressure: none. start is taken only in IDLE, and abort overrides everything.
module counter_sweep_ctrl #(
  parameter int CNT_WIDTH  = 3,
  parameter int LOOP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  lo_bound,
  input  logic [CNT_WIDTH-1:0]  hi_bound,
  input  logic [LOOP_WIDTH-1:0] num_sweeps,
  input  logic [CNT_WIDTH-1:0]  counter_out,
  output logic                  load_en,
  output logic [CNT_WIDTH-1:0]  counter_in,
  output logic                  up_down,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  all_done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_lo;
  logic [CNT_WIDTH-1:0]  r_hi;
  logic [LOOP_WIDTH-1:0] r_sweeps_left;
  logic                  r_sweep_done;
  logic                  r_cfg_err;

  logic w_accept;
  logic w_cfg_bad;
  logic w_at_top;
  logic w_at_bot;
  logic w_sweep_end;

  // A start is only seen in IDLE, and a simultaneous abort cancels it.
  assign w_accept  = (r_state == S_IDLE) && start && !abort;
  assign w_cfg_bad = (lo_bound >= hi_bound) || (num_sweeps == '0);

  // The turn is decided one step early, so the counter lands exactly on hi or lo
  // at the same edge that changes the direction. The inequalities still end the
  // sweep if something outside disturbs counter_out. Because lo < hi,
  // neither hi-1 nor lo+1 can wrap.
  assign w_at_top    = counter_out >= (r_hi - CNT_ONE);
  assign w_at_bot    = counter_out <= (r_lo + CNT_ONE);
  assign w_sweep_end = (r_state == S_DOWN) && w_at_bot && !abort;

  assign sweep_done = r_sweep_done;
  assign cfg_err    = r_cfg_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus the Moore decode of the counter controls and the status outputs.
  always_comb begin
    w_next     = r_state;
    load_en    = 1'b0;
    up_down    = 1'b1;
    counter_in = r_lo;
    busy       = 1'b1;
    all_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_en = 1'b1;
        busy    = 1'b0;
        if (w_accept && !w_cfg_bad) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        w_next  = S_UP;
      end
      S_UP: begin
        if (w_at_top) begin
          w_next = S_DOWN;
        end
      end
      S_DOWN: begin
        up_down = 1'b0;
        if (w_at_bot) begin
          w_next = (r_sweeps_left == LOOP_ONE) ? S_DONE : S_UP;
        end
      end
      S_DONE: begin
        load_en  = 1'b1;
        all_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end
  end

  // Capture the job config on any accepted start, and count down the sweeps as they complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lo          <= '0;
      r_hi          <= '0;
      r_sweeps_left <= '0;
    end else if (w_accept) begin
      r_lo          <= lo_bound;
      r_hi          <= hi_bound;
      r_sweeps_left <= num_sweeps;
    end else if (w_sweep_end) begin
      r_sweeps_left <= r_sweeps_left - LOOP_ONE;
    end
  end

  // Registered one-cycle pulses for each finished sweep and for each rejected config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sweep_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_sweep_done <= w_sweep_end;
      r_cfg_err    <= w_accept && w_cfg_bad;
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl. It wires the DUT to a behavioural up/down/load counter.
// Inputs are driven at the falling edge, and outputs are sampled at the falling edge.
// Every expected value is written out directly here or built from the sweep definition.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [2:0] lo_bound;
  logic [2:0] hi_bound;
  logic [3:0] num_sweeps;
  logic [2:0] cnt;
  logic       load_en;
  logic [2:0] counter_in;
  logic       up_down;
  logic       busy;
  logic       sweep_done;
  logic       all_done;
  logic       cfg_err;

  int n_chk = 0;
  int n_err = 0;

  int busy_cyc;
  int n_sw;
  int n_all;
  int got_q[$];
  int exp_q[$];

  counter_sweep_ctrl #(.CNT_WIDTH(3), .LOOP_WIDTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .lo_bound    (lo_bound),
    .hi_bound    (hi_bound),
    .num_sweeps  (num_sweeps),
    .counter_out (cnt),
    .load_en     (load_en),
    .counter_in  (counter_in),
    .up_down     (up_down),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .all_done    (all_done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter. It shares reset_n with the DUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (load_en) cnt <= counter_in;
    else if (up_down) cnt <= cnt + 3'd1;
    else              cnt <= cnt - 3'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Run one legal job. Record the counter value on every busy cycle after LOAD,
  // and count the pulses up to one cycle past busy.
  task automatic run_job(input logic [2:0] lo, input logic [2:0] hi, input logic [3:0] num);
    int  guard;
    bit  first;
    got_q.delete();
    busy_cyc = 0;
    n_sw     = 0;
    n_all    = 0;
    @(negedge clk);
    start = 1'b1; lo_bound = lo; hi_bound = hi; num_sweeps = num;
    @(negedge clk);
    start = 1'b0; lo_bound = 3'($urandom); hi_bound = 3'($urandom); num_sweeps = 4'($urandom);
    guard = 0;
    first = 1'b1;
    while (busy && guard < 300) begin
      busy_cyc++;
      if (sweep_done) n_sw++;
      if (all_done)   n_all++;
      if (!first) got_q.push_back(int'(cnt));
      first = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk("job_ends_in_budget", int'(busy), 0);
    if (sweep_done) n_sw++;
    if (all_done)   n_all++;
    chk("park_at_lo", int'(cnt), int'(lo));
  endtask

  // Check the recorded job against the expected counter trace, busy length and pulse counts.
  task automatic check_job(input string tag, input int lo, input int hi, input int num);
    exp_q.delete();
    for (int s = 0; s < num; s++) begin
      for (int v = lo; v < hi; v++)      exp_q.push_back(v);
      for (int v = hi; v > lo; v--)      exp_q.push_back(v);
    end
    exp_q.push_back(lo);
    chk({tag, "_busy_cycles"}, busy_cyc, 2 + num * 2 * (hi - lo));
    chk({tag, "_sweep_done"}, n_sw, num);
    chk({tag, "_all_done"}, n_all, 1);
    chk({tag, "_trace_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_trace[%0d]", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int guard;
    int seen_all;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    lo_bound = '0; hi_bound = '0; num_sweeps = '0;

    // While reset is held: registered outputs must be 0, with the IDLE Moore controls.
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_load_en", int'(load_en), 1);
    chk("rst_counter_in", int'(counter_in), 0);
    chk("rst_up_down", int'(up_down), 1);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_all_done", int'(all_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_cnt", int'(cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: lo=2, hi=5, two sweeps.
    run_job(3'd2, 3'd5, 4'd2);
    check_job("t1", 2, 5, 2);

    // Test 2: full range. The counter must not wrap.
    run_job(3'd0, 3'd7, 4'd1);
    check_job("t2", 0, 7, 1);

    // Test 3: hi = lo+1. UP and DOWN each last one cycle.
    run_job(3'd3, 3'd4, 4'd3);
    check_job("t3", 3, 4, 3);

    // Test 4: rejected configs. Each one gives a single cfg_err pulse and leaves busy low.
    @(negedge clk);
    start = 1'b1; lo_bound = 3'd5; hi_bound = 3'd5; num_sweeps = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("t4a_cfg_err", int'(cfg_err), 1);
    chk("t4a_busy", int'(busy), 0);
    @(negedge clk);
    chk("t4a_cfg_err_pulse", int'(cfg_err), 0);
    start = 1'b1; lo_bound = 3'd1; hi_bound = 3'd4; num_sweeps = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t4b_cfg_err", int'(cfg_err), 1);
    chk("t4b_busy", int'(busy), 0);
    @(negedge clk);
    chk("t4b_cfg_err_pulse", int'(cfg_err), 0);
    chk("t4b_busy_after", int'(busy), 0);

    // An abort in IDLE with a simultaneous legal start: nothing happens.
    start = 1'b1; abort = 1'b1; lo_bound = 3'd1; hi_bound = 3'd3; num_sweeps = 4'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_cfg_err", int'(cfg_err), 0);

    // Test 5: lo=2, hi=6. A start while busy is ignored; then abort in UP at counter 4.
    start = 1'b1; lo_bound = 3'd2; hi_bound = 3'd6; num_sweeps = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_load_busy", int'(busy), 1);
    @(negedge clk);
    chk("t5_up_cnt2", int'(cnt), 2);
    start = 1'b1; lo_bound = 3'd0; hi_bound = 3'd7; num_sweeps = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("t5_up_cnt3", int'(cnt), 3);
    @(negedge clk);
    chk("t5_up_cnt4", int'(cnt), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_busy", int'(busy), 0);
    chk("t5_abort_all_done", int'(all_done), 0);
    chk("t5_abort_cnt5", int'(cnt), 5);
    @(negedge clk);
    chk("t5_reload_lo", int'(cnt), 2);
    chk("t5_counter_in", int'(counter_in), 2);

    // Test 6: reset in DOWN. busy and the counter clear at once; then a fresh job runs.
    @(negedge clk);
    start = 1'b1; lo_bound = 3'd1; hi_bound = 3'd5; num_sweeps = 4'd2;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    seen_all = 0;
    while (!(busy && !load_en && !up_down) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_reached_down", int'(busy && !load_en && !up_down), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_cnt", int'(cnt), 0);
    chk("t6_rst_load_en", int'(load_en), 1);
    chk("t6_rst_up_down", int'(up_down), 1);
    chk("t6_rst_counter_in", int'(counter_in), 0);
    @(negedge clk);
    if (all_done) seen_all++;
    reset_n = 1'b1;
    @(negedge clk);
    if (all_done) seen_all++;
    chk("t6_no_all_done", seen_all, 0);
    run_job(3'd3, 3'd6, 4'd1);
    check_job("t6", 3, 6, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
